// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
//   Shared reorder-buffer definitions: sizing constants, the per-entry record
//   and the live-range test that pipeline registers use to recognise stale
//   instructions after a flush.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH  = 8;
    localparam int unsigned ROB_ADDR_W = $clog2(ROB_DEPTH);
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DATA_W     = 8;

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  mispredict;
        logic                  write_dst;
        logic [REG_ADDR_W-1:0] rw_addr;
        logic [DATA_W-1:0]     data;
    } rob_entry_t;

    // Entry idx is live when its distance from head (mod depth) is below count.
    // The subtraction wraps naturally in ROB_ADDR_W bits.
    function automatic logic rob_live(
        input logic [ROB_ADDR_W-1:0] idx,
        input logic [ROB_ADDR_W-1:0] head,
        input logic [ROB_ADDR_W:0]   count
    );
        logic [ROB_ADDR_W-1:0] offset;
        offset = idx - head;
        return ({1'b0, offset} < count);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement buffer. Dispatch allocates at the tail, completion
//   marks entries done, and the head entry retires to the register-file
//   write port once done. Retiring a mispredicted branch empties the buffer
//   and pulses flush for one cycle.
//
// Ports
//   clk, n_rst                     clock, asynchronous active-low reset
//   alloc_valid/write_dst/rw_addr  dispatch request
//   alloc_ready, alloc_rob_addr    grant and index granted (current tail)
//   cmp_valid/rob_addr/data/mispredict  completion strobe
//   retire_valid/write/addr/data   registered retirement port
//   flush                          registered one-cycle flush
//   range_head, range_count        live window for stale-instruction kill
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_DEPTH  = reorder_buffer_pkg::ROB_DEPTH,
    parameter int unsigned ROB_ADDR_W = $clog2(ROB_DEPTH),
    parameter int unsigned REG_ADDR_W = reorder_buffer_pkg::REG_ADDR_W,
    parameter int unsigned DATA_W     = reorder_buffer_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  n_rst,

    input  logic                  alloc_valid,
    input  logic                  alloc_write_dst,
    input  logic [REG_ADDR_W-1:0] alloc_rw_addr,
    output logic                  alloc_ready,
    output logic [ROB_ADDR_W-1:0] alloc_rob_addr,

    input  logic                  cmp_valid,
    input  logic [ROB_ADDR_W-1:0] cmp_rob_addr,
    input  logic [DATA_W-1:0]     cmp_data,
    input  logic                  cmp_mispredict,

    output logic                  retire_valid,
    output logic                  retire_write,
    output logic [REG_ADDR_W-1:0] retire_addr,
    output logic [DATA_W-1:0]     retire_data,
    output logic                  flush,

    output logic [ROB_ADDR_W-1:0] range_head,
    output logic [ROB_ADDR_W:0]   range_count
);

    localparam logic [ROB_ADDR_W:0] FULL_COUNT = (ROB_ADDR_W+1)'(ROB_DEPTH);
    localparam logic [ROB_ADDR_W:0] PTR_ONE    = (ROB_ADDR_W+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ROB_ADDR_W:0]   head;
    logic [ROB_ADDR_W:0]   tail;
    logic [ROB_ADDR_W:0]   count;
    logic [ROB_ADDR_W-1:0] head_idx;
    logic [ROB_ADDR_W-1:0] tail_idx;

    rob_entry_t entries [ROB_DEPTH];
    rob_entry_t head_entry;

    logic alloc_fire;
    logic cmp_fire;
    logic retire_fire;

    always_comb begin
        count       = tail - head;
        head_idx    = head[ROB_ADDR_W-1:0];
        tail_idx    = tail[ROB_ADDR_W-1:0];
        head_entry  = entries[head_idx];

        alloc_ready    = (count < FULL_COUNT) & ~flush;
        alloc_rob_addr = tail_idx;
        range_head     = head_idx;
        range_count    = count;

        alloc_fire  = alloc_valid & alloc_ready;
        cmp_fire    = cmp_valid & rob_live(cmp_rob_addr, head_idx, count);
        retire_fire = (count != '0) & head_entry.busy & head_entry.done;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head         <= '0;
            tail         <= '0;
            entries      <= '{default: '0};
            retire_valid <= 1'b0;
            retire_write <= 1'b0;
            retire_addr  <= '0;
            retire_data  <= '0;
            flush        <= 1'b0;
        end else begin
            flush <= 1'b0;

            if (alloc_fire) begin
                entries[tail_idx] <= '{busy: 1'b1, done: 1'b0, mispredict: 1'b0,
                                       write_dst: alloc_write_dst,
                                       rw_addr: alloc_rw_addr, data: '0};
                tail <= tail + PTR_ONE;
            end

            if (cmp_fire) begin
                entries[cmp_rob_addr].done       <= 1'b1;
                entries[cmp_rob_addr].data       <= cmp_data;
                entries[cmp_rob_addr].mispredict <= cmp_mispredict;
            end

            if (retire_fire) begin
                retire_valid <= 1'b1;
                retire_write <= head_entry.write_dst;
                retire_addr  <= head_entry.rw_addr;
                retire_data  <= head_entry.data;
                head         <= head + PTR_ONE;
                entries[head_idx].busy <= 1'b0;
                entries[head_idx].done <= 1'b0;

                // Written after the allocate/complete updates above so the
                // mispredict clean-up wins: any same-cycle allocation or
                // completion is discarded along with the younger entries.
                if (head_entry.mispredict) begin
                    flush <= 1'b1;
                    tail  <= head + PTR_ONE;
                    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                        entries[ROB_ADDR_W'(i)].busy <= 1'b0;
                        entries[ROB_ADDR_W'(i)].done <= 1'b0;
                    end
                end
            end else begin
                retire_valid <= 1'b0;
                retire_write <= 1'b0;
            end
        end
    end

endmodule
